ofifo_drain: RTL and testbench

OFIFO_DRAIN -- requirements
Module: ofifo_drain

---
 rtl/ofifo_drain_pkg.sv | 15 +
 rtl/ofifo_drain_relu.sv | 18 +
 rtl/ofifo_drain.sv | 128 ++++++++++++
 tb/tb_ofifo_drain.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofifo_drain_pkg.sv
// ofifo_drain_pkg: shared types and default geometry for the OFIFO drain block.
// The optional ReLU stage is enabled by defining OFIFO_DRAIN_RELU_EN.
package ofifo_drain_pkg;

  localparam int COL_DEFAULT    = 8;
  localparam int BW_DEFAULT     = 4;
  localparam int ADDR_W_DEFAULT = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    FINISH = 2'd2
  } drainState_t;

endpackage

// File: rtl/ofifo_drain_relu.sv
// drain_relu: clamps one two's-complement column word to zero when negative.
// Only compiled when OFIFO_DRAIN_RELU_EN is defined, because the drain top
// instantiates it only in that configuration.
`ifdef OFIFO_DRAIN_RELU_EN
module drain_relu
  import ofifo_drain_pkg::*;
#(
  parameter int bw = BW_DEFAULT
) (
  input  logic [bw-1:0] i_word,
  output logic [bw-1:0] o_word
);

  // The sign bit alone decides whether the word survives.
  assign o_word = i_word[bw-1] ? '0 : i_word;

endmodule
`endif

// File: rtl/ofifo_drain.sv
// ofifo_drain: pops rows from a show-ahead output FIFO and writes them to
// consecutive SRAM addresses starting at base_addr, one row per cycle.
// Define OFIFO_DRAIN_RELU_EN to clamp negative column words to zero on the
// way to the SRAM; latency and ports are identical either way.
module ofifo_drain
  import ofifo_drain_pkg::*;
#(
  parameter int col    = COL_DEFAULT,
  parameter int bw     = BW_DEFAULT,
  parameter int addr_w = ADDR_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [addr_w:0]     num_rows,
  input  logic [addr_w-1:0]   base_addr,
  input  logic                stall,
  input  logic [col*bw-1:0]   fifo_out,
  input  logic                fifo_valid,
  output logic                fifo_rd,
  output logic                sram_cen,
  output logic                sram_wen,
  output logic [addr_w-1:0]   sram_addr,
  output logic [col*bw-1:0]   sram_d,
  output logic                busy,
  output logic                done
);

  localparam int W = col * bw;
  localparam logic [addr_w:0] LAST_ROW = (addr_w+1)'(1);

  drainState_t       r_state;
  drainState_t       w_nextState;
  logic [addr_w:0]   r_rows;
  logic [addr_w-1:0] r_addr;
  logic              r_wr;
  logic              r_done;
  logic [W-1:0]      r_sramD;
  logic [W-1:0]      w_writeData;
  logic              w_pop;
  logic              w_accept;

`ifdef OFIFO_DRAIN_RELU_EN
  for (genvar c = 0; c < col; c++) begin : g_relu
    drain_relu #(.bw(bw)) u_relu (
      .i_word (fifo_out[c*bw +: bw]),
      .o_word (w_writeData[c*bw +: bw])
    );
  end
`else
  assign w_writeData = fifo_out;
`endif

  // Next-state and pop decision; a pop only happens while rows remain.
  always_comb begin
    w_nextState = r_state;
    w_pop       = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_nextState = (num_rows != '0) ? DRAIN : FINISH;
        end
      end
      DRAIN: begin
        w_pop = fifo_valid && !stall && (r_rows != '0);
        if (r_rows == '0) begin
          w_nextState = FINISH;
        end else if (w_pop && (r_rows == LAST_ROW)) begin
          w_nextState = FINISH;
        end
      end
      FINISH: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // State register; reset returns to IDLE regardless of other inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Row counter, address, one-cycle write pipeline and done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rows  <= '0;
      r_addr  <= '0;
      r_wr    <= 1'b0;
      r_sramD <= '0;
      r_done  <= 1'b0;
    end else begin
      r_wr   <= w_pop;
      r_done <= (r_state == FINISH);
      if (w_accept) begin
        r_rows <= num_rows;
        r_addr <= base_addr;
      end else begin
        if (w_pop) begin
          r_rows <= r_rows - 1'b1;
        end
        if (r_wr) begin
          r_addr <= r_addr + 1'b1;
        end
      end
      if (w_pop) begin
        r_sramD <= w_writeData;
      end
    end
  end

  assign fifo_rd   = w_pop && !reset;
  assign sram_cen  = !r_wr;
  assign sram_wen  = !r_wr;
  assign sram_addr = r_addr;
  assign sram_d    = r_sramD;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_ofifo_drain.sv
// tb_ofifo_drain: randomized scoreboard bench for ofifo_drain. A FIFO model
// feeds rows; every job pushes its expected SRAM writes (address, data) into
// a queue that a negedge monitor drains. Honours OFIFO_DRAIN_RELU_EN.
module tb_ofifo_drain;
  import ofifo_drain_pkg::*;

  localparam int COL = COL_DEFAULT;
  localparam int BW  = BW_DEFAULT;
  localparam int AW  = ADDR_W_DEFAULT;
  localparam int W   = COL * BW;

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } expWrite_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW:0]   num_rows;
  logic [AW-1:0] base_addr;
  logic          stall;
  logic [W-1:0]  fifo_out;
  logic          fifo_valid;
  logic          fifo_rd;
  logic          sram_cen;
  logic          sram_wen;
  logic [AW-1:0] sram_addr;
  logic [W-1:0]  sram_d;
  logic          busy;
  logic          done;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [W-1:0] fifoQ[$];
  logic [W-1:0] directedRows[$];
  expWrite_t    expQ[$];
  bit           validPattern[$];
  bit           stallPattern[$];
  int           validPct = 100;
  int           stallPct = 0;
  bit           popPending = 0;
  bit           monOn = 0;
  bit           prevPop = 0;

  ofifo_drain #(.col(COL), .bw(BW), .addr_w(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .num_rows   (num_rows),
    .base_addr  (base_addr),
    .stall      (stall),
    .fifo_out   (fifo_out),
    .fifo_valid (fifo_valid),
    .fifo_rd    (fifo_rd),
    .sram_cen   (sram_cen),
    .sram_wen   (sram_wen),
    .sram_addr  (sram_addr),
    .sram_d     (sram_d),
    .busy       (busy),
    .done       (done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Reference for the data path: optional ReLU applied word by word.
  function automatic logic [W-1:0] modelRow(input logic [W-1:0] row);
    logic [W-1:0] result;
    result = row;
`ifdef OFIFO_DRAIN_RELU_EN
    for (int c = 0; c < COL; c++) begin
      int word;
      word = int'(row[c*BW +: BW]);
      if (word >= (1 << (BW - 1))) begin
        result[c*BW +: BW] = '0;
      end
    end
`endif
    return result;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // FIFO model: pops the head after a strobed edge, then offers new inputs.
  initial begin
    fifo_valid = 1'b0;
    stall      = 1'b0;
    fifo_out   = '0;
    forever begin
      bit v;
      bit s;
      @(posedge clk);
      #1;
      if (popPending) begin
        if (fifoQ.size() > 0) void'(fifoQ.pop_front());
        popPending = 0;
      end
      if (validPattern.size() > 0) v = validPattern.pop_front();
      else v = ($urandom_range(99) < validPct);
      if (stallPattern.size() > 0) s = stallPattern.pop_front();
      else s = ($urandom_range(99) < stallPct);
      fifo_valid = (fifoQ.size() > 0) && v;
      stall      = s;
      if (fifoQ.size() > 0) fifo_out = fifoQ[0];
      else fifo_out = W'($urandom);
      @(negedge clk);
      if (fifo_rd) popPending = 1;
    end
  end

  // Monitor: pop legality, one-cycle write latency and scoreboard compare.
  initial begin
    forever begin
      @(negedge clk);
      if (monOn) begin
        if (fifo_rd) begin
          checkOutput("popLegal", {62'b0, fifo_valid && !stall, busy}, 64'h3);
        end
        checkOutput("writeLatency", sram_cen, !prevPop);
        if (!sram_cen) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpectedWrite", 1, 0);
          end else begin
            expWrite_t e;
            e = expQ.pop_front();
            checkOutput("writeAddr", sram_addr, e.addr);
            checkOutput("writeData", sram_d, e.data);
            checkOutput("writeWen", sram_wen, 0);
          end
        end
        prevPop = fifo_rd;
      end
    end
  end

  // One drain job: load FIFO rows, expect contiguous writes, time done.
  task automatic applyStimulus(input int n, input int base, input int vPct, input int sPct, input bit ignoredStart);
    int idx;
    int writes;
    int lastIdx;
    int doneIdx;
    bit sawDone;
    for (int k = 0; k < n; k++) begin
      logic [W-1:0] row;
      expWrite_t e;
      if (directedRows.size() > 0) row = directedRows.pop_front();
      else for (int b = 0; b < W; b++) row[b] = 1'($urandom_range(0, 1));
      fifoQ.push_back(row);
      e.addr = AW'((base + k) % (1 << AW));
      e.data = modelRow(row);
      expQ.push_back(e);
    end
    validPct = vPct;
    stallPct = sPct;
    writes = 0; lastIdx = 0; doneIdx = 0; sawDone = 0;
    @(negedge clk);
    start = 1'b1; num_rows = (AW+1)'(n); base_addr = AW'(base);
    @(negedge clk);
    start = 1'b0; num_rows = (AW+1)'($urandom); base_addr = AW'($urandom);
    checkOutput("busyAfterStart", busy, 1);
    idx = 1;
    while (idx < 300) begin
      if (!sram_cen) begin
        writes++;
        lastIdx = idx;
      end
      if (done) begin
        doneIdx = idx;
        sawDone = 1;
        break;
      end
      if (ignoredStart && idx == 3) begin
        start = 1'b1; num_rows = (AW+1)'(5); base_addr = AW'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      idx++;
    end
    start = 1'b0;
    checkOutput("doneSeen", sawDone, 1);
    if (sawDone) begin
      checkOutput("doneTiming", doneIdx, (n == 0) ? 2 : lastIdx + 1);
      checkOutput("writeCount", writes, n);
      checkOutput("idleAtDone", busy, 0);
      @(negedge clk);
      checkOutput("donePulse", done, 0);
      checkOutput("scoreboardEmpty", expQ.size(), 0);
    end else begin
      expQ.delete();
      fifoQ.delete();
    end
    validPattern.delete();
    stallPattern.delete();
    validPct = 100;
    stallPct = 0;
  endtask

  // Reset after two of eight rows are written, then check reset values.
  task automatic applyResetMidDrain();
    int writes;
    int idx;
    for (int k = 0; k < 8; k++) begin
      logic [W-1:0] row;
      expWrite_t e;
      row = W'($urandom);
      fifoQ.push_back(row);
      e.addr = AW'(8'h20 + k);
      e.data = modelRow(row);
      expQ.push_back(e);
    end
    validPct = 100;
    stallPct = 0;
    @(negedge clk);
    start = 1'b1; num_rows = (AW+1)'(8); base_addr = AW'(8'h20);
    @(negedge clk);
    start = 1'b0;
    writes = 0;
    idx = 0;
    while (writes < 2 && idx < 50) begin
      if (!sram_cen) writes++;
      if (writes < 2) @(negedge clk);
      idx++;
    end
    checkOutput("resetPreWrites", writes, 2);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("midResetFifoRd", fifo_rd, 0);
    checkOutput("midResetCen", sram_cen, 1);
    checkOutput("midResetWen", sram_wen, 1);
    checkOutput("midResetAddr", sram_addr, 0);
    checkOutput("midResetData", sram_d, 0);
    checkOutput("midResetBusy", busy, 0);
    checkOutput("midResetDone", done, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    fifoQ.delete();
    expQ.delete();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence: reset, directed scenarios, then randomized jobs.
  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    num_rows  = '0;
    base_addr = '0;
    repeat (3) @(negedge clk);
    checkOutput("resetFifoRd", fifo_rd, 0);
    checkOutput("resetCen", sram_cen, 1);
    checkOutput("resetWen", sram_wen, 1);
    checkOutput("resetAddr", sram_addr, 0);
    checkOutput("resetData", sram_d, 0);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDone", done, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    monOn = 1;

    applyStimulus(4, 'h10, 100, 0, 0);

    validPattern = '{0, 1, 0, 0, 1, 1};
    applyStimulus(3, 'h05, 100, 0, 0);

    stallPattern = '{0, 0, 0, 1, 1, 1, 1, 1};
    applyStimulus(6, 'h30, 100, 0, 0);

    applyStimulus(4, 'h3E, 100, 0, 0);

    applyStimulus(0, 'h12, 100, 0, 0);

    applyStimulus(5, 'h08, 100, 0, 1);

    applyResetMidDrain();
    applyStimulus(3, 'h01, 100, 0, 0);

    directedRows.push_back(32'h3333_337F);
    applyStimulus(1, 'h2A, 100, 0, 0);

    for (int j = 0; j < 10; j++) begin
      int n;
      n = $urandom_range(0, 9);
      applyStimulus(n, $urandom_range(0, 63), $urandom_range(50, 100), $urandom_range(0, 30), n >= 4);
    end

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
